sprite_scheduler: RTL

SPRITE_SCHEDULER -- requirements
Module: sprite_scheduler

---
 rtl/sprite_scheduler.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/sprite_scheduler.sv
// sprite_scheduler
//
// Paces a set of sprite widgets from the VGA raster and composes the final
// pixel colour. A small run/pause/step controller decides whether the
// once-per-frame tick is honoured; each sprite divides that tick by its own
// programmable divider and receives a one-cycle move-enable pulse when its
// count expires. Independently of the controller, the pixel path selects
// the lowest-index covering sprite (or the background) and registers it.
//
// Ports:
//   clk          pixel clock
//   reset        asynchronous, active-high reset
//   X, Y         current scan position from the VGA timing block
//   start        IDLE->RUN, PAUSE->RUN
//   pause        RUN->PAUSE
//   step         PAUSE->STEP (one frame, then back to PAUSE)
//   cfg_we       write strobe for the divider table
//   cfg_idx      sprite index to write
//   cfg_div      frames per move, minus 1
//   spr_yes      per-sprite coverage flags
//   spr_rgb      per-sprite colours, sprite i in bits [12i+11:12i]
//   bg_rgb       background colour
//   enable       per-sprite move-enable pulses
//   red/green/blue  registered pixel colour
//   busy         high while in RUN
//   frame_count  frames elapsed while in RUN or STEP

module sprite_scheduler #(
  parameter int NUM_SPR   = 4,
  parameter int V_VISIBLE = 600,
  parameter int H_VISIBLE = 800
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [10:0]            X,
  input  logic [10:0]            Y,
  input  logic                   start,
  input  logic                   pause,
  input  logic                   step,
  input  logic                   cfg_we,
  input  logic [1:0]             cfg_idx,
  input  logic [3:0]             cfg_div,
  input  logic [NUM_SPR-1:0]     spr_yes,
  input  logic [12*NUM_SPR-1:0]  spr_rgb,
  input  logic [11:0]            bg_rgb,
  output logic [NUM_SPR-1:0]     enable,
  output logic [3:0]             red,
  output logic [3:0]             green,
  output logic [3:0]             blue,
  output logic                   busy,
  output logic [15:0]            frame_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    STEP  = 2'd3
  } state_t;

  state_t      state;
  logic        armed;
  logic        ftick;
  logic        tick_live;
  logic [3:0]  div [NUM_SPR];
  logic [3:0]  cnt [NUM_SPR];
  logic [11:0] pix_sel;

  // The tick fires on the first X==0 cycle of the first non-visible line.
  // It is only counted as a frame event when the controller is in RUN or
  // STEP; in the other states it still disarms, so a late start cannot
  // produce a second tick in the same frame.
  assign ftick     = armed && (X == 11'd0) && (Y == 11'(V_VISIBLE));
  assign tick_live = ftick && ((state == RUN) || (state == STEP));

  // Tick arming: once fired, stay disarmed until the raster leaves the
  // trigger line, so holding X/Y at the trigger point cannot retrigger.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armed <= 1'b1;
    end else if (Y != 11'(V_VISIBLE)) begin
      armed <= 1'b1;
    end else if (ftick) begin
      armed <= 1'b0;
    end
  end

  // Run controller. busy is registered alongside the state so it changes
  // on the same edge. STEP ignores all strobes and leaves only after the
  // tick it was waiting for, which is processed using the STEP state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (pause) begin
            state <= PAUSE;
            busy  <= 1'b0;
          end
        end
        PAUSE: begin
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
          end else if (step) begin
            state <= STEP;
          end
        end
        STEP: begin
          if (ftick) begin
            state <= PAUSE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Frame counter, wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_count <= 16'd0;
    end else if (tick_live) begin
      frame_count <= frame_count + 16'd1;
    end
  end

  // Per-sprite dividers. A configuration write to a sprite takes priority
  // over a coincident tick: the divider is replaced, the count restarts
  // and that sprite gets no pulse for this frame. enable defaults low so
  // every pulse lasts exactly one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable <= '0;
      for (int i = 0; i < NUM_SPR; i++) begin
        div[i] <= 4'd0;
        cnt[i] <= 4'd0;
      end
    end else begin
      enable <= '0;
      for (int i = 0; i < NUM_SPR; i++) begin
        if (cfg_we && (int'(cfg_idx) == i)) begin
          div[i] <= cfg_div;
          cnt[i] <= 4'd0;
        end else if (tick_live) begin
          if (cnt[i] == div[i]) begin
            enable[i] <= 1'b1;
            cnt[i]    <= 4'd0;
          end else begin
            cnt[i] <= cnt[i] + 4'd1;
          end
        end
      end
    end
  end

  // Pixel priority: scanning from the highest index down lets the lowest
  // covering sprite overwrite the others. Outside the visible area the
  // colour is blanked regardless of coverage.
  always_comb begin
    pix_sel = bg_rgb;
    for (int i = NUM_SPR - 1; i >= 0; i--) begin
      if (spr_yes[i]) begin
        pix_sel = spr_rgb[12*i +: 12];
      end
    end
    if ((X >= 11'(H_VISIBLE)) || (Y >= 11'(V_VISIBLE))) begin
      pix_sel = 12'h000;
    end
  end

  // Registered colour output, active in every controller state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      red   <= 4'd0;
      green <= 4'd0;
      blue  <= 4'd0;
    end else begin
      red   <= pix_sel[11:8];
      green <= pix_sel[7:4];
      blue  <= pix_sel[3:0];
    end
  end

endmodule
